// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - Round-robin burst arbiter sharing one FIFO write port
// Stalls on FIFO full, times out long stalls, and holds off grants while mrk_flg is set.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int STALL_MAX = 64
) (
    input  logic                clk_w,
    input  logic                rst_w,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    input  logic                full,
    input  logic                mrk_flg,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                wr_en,
    output logic [DW-1:0]       wr_data,
    output logic                busy,
    output logic                stall_to
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST);
    localparam int SW = $clog2(STALL_MAX);

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]    gidx, gidx_nxt;
    logic [BW-1:0]    burst_cnt, burst_cnt_nxt;
    logic [SW-1:0]    stall_cnt, stall_cnt_nxt;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    g_inc;
    logic             exit_burst;

    // Scan from rr_ptr upward with explicit modulo so non-power-of-2 N_REQ wraps correctly
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(rr_ptr) + k) % N_REQ;
            cand = PW'(idx);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign g_inc = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gidx_nxt      = gidx;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        stall_cnt_nxt = stall_cnt;
        wr_en         = 1'b0;
        ack           = '0;
        wr_data       = '0;
        stall_to      = 1'b0;
        exit_burst    = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (!mrk_flg && pick_found) begin
                    state_nxt     = BURST;
                    gidx_nxt      = pick_idx;
                    gnt_nxt       = N_REQ'(1) << pick_idx;
                    burst_cnt_nxt = '0;
                    stall_cnt_nxt = '0;
                end
            end
            BURST: begin
                wr_en = req[gidx] & ~full & ~mrk_flg;
                if (wr_en) begin
                    wr_data       = req_data[int'(gidx)*DW +: DW];
                    ack           = N_REQ'(1) << gidx;
                    burst_cnt_nxt = burst_cnt + BW'(1);
                    stall_cnt_nxt = '0;
                end else if (req[gidx] && full) begin
                    stall_cnt_nxt = stall_cnt + SW'(1);
                end
                if (!req[gidx] || mrk_flg) begin
                    exit_burst = 1'b1;
                end else if (wr_en && (req_last[gidx] || burst_cnt == BW'(MAX_BURST - 1))) begin
                    exit_burst = 1'b1;
                end else if (full && stall_cnt == SW'(STALL_MAX - 1)) begin
                    exit_burst = 1'b1;
                    stall_to   = 1'b1;
                end
                // Pointer advances past the owner on every exit cause, so no requester can hog
                if (exit_burst) begin
                    state_nxt  = RELEASE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = g_inc;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            state     <= IDLE;
            gnt       <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gidx      <= gidx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - Directed and randomized checks for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk_w;
    logic        rst_w;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        full;
    logic        mrk_flg;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        stall_to;

    int passed = 0;
    int total  = 0;

    fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(16), .STALL_MAX(64)) dut (
        .clk_w(clk_w), .rst_w(rst_w), .req(req), .req_data(req_data), .req_last(req_last),
        .full(full), .mrk_flg(mrk_flg), .gnt(gnt), .ack(ack), .wr_en(wr_en),
        .wr_data(wr_data), .busy(busy), .stall_to(stall_to)
    );

    initial clk_w = 1'b0;
    always #5 clk_w = ~clk_w;

    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic apply_reset();
        rst_w = 1'b0; req = '0; req_last = '0; full = 1'b0; mrk_flg = 1'b0;
        repeat (2) @(posedge clk_w);
        #1 rst_w = 1'b1;
    endtask

    task automatic test_reset();
        rst_w = 1'b0; req = 4'b1111; req_last = '0; full = 1'b0; mrk_flg = 1'b0;
        repeat (3) tick();
        #1;
        total++;
        if ({gnt, ack, wr_en, wr_data, busy, stall_to} !== 19'd0)
            $display("FAIL reset_outputs: got %h want 0", {gnt, ack, wr_en, wr_data, busy, stall_to});
        else passed++;
        apply_reset();
    endtask

    task automatic test_single_burst();
        apply_reset();
        req = 4'b0001;
        #1;
        total++;
        if ({gnt, wr_en, busy} !== 6'd0) $display("FAIL single_idle: got %h want 0", {gnt, wr_en, busy});
        else passed++;
        tick();
        for (int w = 0; w < 3; w++) begin
            req_last = (w == 2) ? 4'b0001 : 4'b0000;
            #1;
            total++;
            if ({gnt, wr_en, ack, wr_data} !== {4'b0001, 1'b1, 4'b0001, 8'hA0})
                $display("FAIL single_word%0d: got %h want %h", w, {gnt, wr_en, ack, wr_data},
                         {4'b0001, 1'b1, 4'b0001, 8'hA0});
            else passed++;
            tick();
        end
        req = '0; req_last = '0;
        #1;
        total++;
        if ({gnt, wr_en, busy} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL single_release: got %b want 000001", {gnt, wr_en, busy});
        else passed++;
        tick();
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL single_idle_after: got %b want 0", busy);
        else passed++;
        req = 4'b1111;
        tick();
        #1;
        total++;
        if (gnt !== 4'b0010) $display("FAIL single_rr_ptr: got %b want 0010", gnt);
        else passed++;
        req = '0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        int         words;
        apply_reset();
        req = 4'b1111;
        tick();
        for (int gi = 0; gi < 5; gi++) begin
            exp_g = 4'b0001 << (gi % 4);
            exp_d = 8'hA0 + 8'(gi % 4);
            words = 0;
            for (int c = 0; c < 16; c++) begin
                #1;
                if (gnt == exp_g && wr_en && ack == exp_g && wr_data == exp_d) words++;
                tick();
            end
            total++;
            if (words !== 16) $display("FAIL b2b_burst%0d: got %0d good words want 16 (gnt %b)", gi, words, exp_g);
            else passed++;
            if (gi == 4) req = '0;
            #1;
            total++;
            if ({gnt, wr_en} !== 5'd0) $display("FAIL b2b_gap_release%0d: got %b want 00000", gi, {gnt, wr_en});
            else passed++;
            tick();
            #1;
            total++;
            if ({gnt, busy} !== 5'd0) $display("FAIL b2b_gap_idle%0d: got %b want 00000", gi, {gnt, busy});
            else passed++;
            tick();
        end
    endtask

    task automatic test_full_stall();
        int bad;
        int n;
        int hit;
        apply_reset();
        req = 4'b0001;
        tick();
        repeat (2) tick();
        full = 1'b1;
        bad  = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (wr_en || ack != 4'b0000 || gnt != 4'b0001 || stall_to) bad++;
            tick();
        end
        total++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        else passed++;
        full = 1'b0;
        n    = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (gnt == 4'b0000) break;
            if (wr_en) n++;
            tick();
        end
        total++;
        if (n !== 14) $display("FAIL stall_resume_words: got %0d want 14", n);
        else passed++;

        apply_reset();
        req = 4'b0001;
        tick();
        full = 1'b1;
        hit  = -1;
        bad  = 0;
        for (int k = 0; k < 70; k++) begin
            #1;
            if (wr_en) bad++;
            if (stall_to) begin
                hit = k;
                break;
            end
            tick();
        end
        total++;
        if (hit !== 63 || bad !== 0) $display("FAIL stall_timeout_cycle: got %0d (writes %0d) want 63 (writes 0)", hit, bad);
        else passed++;
        tick();
        #1;
        total++;
        if ({gnt, stall_to, busy} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL stall_timeout_release: got %b want 000001", {gnt, stall_to, busy});
        else passed++;
        full = 1'b0; req = '0;
        tick(); tick();
    endtask

    task automatic test_marker();
        int bad;
        apply_reset();
        req = 4'b0001;
        tick();
        #1;
        total++;
        if (wr_en !== 1'b1) $display("FAIL mrk_pre_write: got %b want 1", wr_en);
        else passed++;
        tick();
        mrk_flg = 1'b1;
        #1;
        total++;
        if ({wr_en, ack, gnt} !== {1'b0, 4'b0000, 4'b0001})
            $display("FAIL mrk_block_write: got %b want 000000001", {wr_en, ack, gnt});
        else passed++;
        tick();
        #1;
        total++;
        if ({gnt, busy} !== {4'b0000, 1'b1}) $display("FAIL mrk_release: got %b want 00001", {gnt, busy});
        else passed++;
        req = 4'b1111;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            if (gnt != 4'b0000 || wr_en) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL mrk_hold_off: got %0d granted cycles want 0", bad);
        else passed++;
        mrk_flg = 1'b0;
        tick();
        #1;
        total++;
        if (gnt !== 4'b0010) $display("FAIL mrk_resume: got %b want 0010", gnt);
        else passed++;
        req = '0;
        tick(); tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req = 4'b0010; req_last = 4'b0010;
        tick();
        #1;
        total++;
        if ({wr_en, ack} !== 5'b10010) $display("FAIL rst_pre_burst: got %b want 10010", {wr_en, ack});
        else passed++;
        tick();
        req = '0; req_last = '0;
        tick();
        req = 4'b0100;
        tick();
        repeat (4) tick();
        #1;
        total++;
        if ({wr_en, wr_data} !== {1'b1, 8'hA2}) $display("FAIL rst_fifth_word: got %h want 1a2", {wr_en, wr_data});
        else passed++;
        rst_w = 1'b0;
        #1;
        total++;
        if ({gnt, wr_en, busy, ack} !== 10'd0) $display("FAIL rst_async_clear: got %b want 0", {gnt, wr_en, busy, ack});
        else passed++;
        tick();
        rst_w = 1'b1; req = 4'b1111;
        tick();
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL rst_rr_restart: got %b want 0001", gnt);
        else passed++;
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        int         waitc[4];
        int         maxw;
        int         v_onehot;
        int         v_wr;
        int         v_ack;
        int         nwr;
        logic [3:0] prev_gnt;
        apply_reset();
        maxw = 0; v_onehot = 0; v_wr = 0; v_ack = 0; nwr = 0;
        prev_gnt = '0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
            req_last = 4'($urandom);
            full     = ($urandom_range(3) == 0);
            mrk_flg  = ($urandom_range(15) == 0);
            #1;
            if (!$onehot0(gnt)) v_onehot++;
            if (wr_en && (full || mrk_flg || gnt == 4'b0000)) v_wr++;
            if (ack != (wr_en ? gnt : 4'b0000)) v_ack++;
            if (wr_en) nwr++;
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) waitc[i] = 0;
                    else if (req[i]) waitc[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) waitc[i] = 0;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            prev_gnt = gnt;
            tick();
        end
        total++;
        if (v_onehot !== 0) $display("FAIL rand_onehot: got %0d violations want 0", v_onehot);
        else passed++;
        total++;
        if (v_wr !== 0) $display("FAIL rand_wr_blocked: got %0d violations want 0", v_wr);
        else passed++;
        total++;
        if (v_ack !== 0) $display("FAIL rand_ack_match: got %0d violations want 0", v_ack);
        else passed++;
        total++;
        if (maxw > 4) $display("FAIL rand_starvation: got %0d grants waited want <= 4", maxw);
        else passed++;
        total++;
        if (nwr < 100) $display("FAIL rand_progress: got %0d writes want >= 100", nwr);
        else passed++;
        req = '0; full = 1'b0; mrk_flg = 1'b0;
    endtask

    initial begin
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_full_stall();
        test_marker();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
